// File: rtl/reg_writeback_pkg.sv
// Shared register-file constants and the load-return queue entry type for the write-back path.
package reg_writeback_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned NUM_REGS   = 32;

    localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_fifo.sv
// Load-return queue. Entries stay occupied until popped even when killed, so a killed
// entry still holds its slot and is discarded when it reaches the head.
module reg_writeback_fifo
    import reg_writeback_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               push_i,
    input  wb_entry_t                          push_entry_i,
    input  logic                               pop_i,
    input  logic                               kill_i,
    input  logic [ADDR_WIDTH-1:0]              kill_rd_i,
    output logic [$clog2(DEPTH+1)-1:0]         count_o,
    output wb_entry_t                          head_o,
    output logic [DEPTH-1:0]                   entry_valid_o,
    output logic [DEPTH-1:0][ADDR_WIDTH-1:0]   entry_rd_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    wb_entry_t       mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (kill_i && mem_q[i].valid && (mem_q[i].rd == kill_rd_i)) begin
                    mem_q[i].valid <= 1'b0;
                end
            end
            // Popped slots are invalidated so unoccupied entries never contribute to pend.
            if (pop_i) begin
                mem_q[rd_ptr_q].valid <= 1'b0;
                rd_ptr_q              <= rd_ptr_q + PtrW'(1);
            end
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_entry_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_valid_o[i] = mem_q[i].valid;
            entry_rd_o[i]    = mem_q[i].rd;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/reg_writeback.sv
// Register-file write-side arbiter: merges ALU results and queued load returns into one
// registered write per cycle, with starvation forcing and write-after-write kill.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       alu_valid_i,
    input  logic [ADDR_WIDTH-1:0]      alu_rd_i,
    input  logic [DATA_WIDTH-1:0]      alu_data_i,
    output logic                       alu_stall_o,
    input  logic                       mem_valid_i,
    output logic                       mem_ready_o,
    input  logic [ADDR_WIDTH-1:0]      mem_rd_i,
    input  logic [DATA_WIDTH-1:0]      mem_data_i,
    output logic                       reg_wr_o,
    output logic [ADDR_WIDTH-1:0]      rw_o,
    output logic [DATA_WIDTH-1:0]      bus_w_o,
    output logic [NUM_REGS-1:0]        pend_o,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);
    localparam logic [StW-1:0] StarveMax = StW'(STARVE_LIMIT);

    logic [CntW-1:0]                 count;
    wb_entry_t                       head;
    wb_entry_t                       push_entry;
    logic [DEPTH-1:0]                entry_valid;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_rd;

    logic                  head_occ, forced, alu_issue, fifo_issue, pop, push, issue;
    logic [ADDR_WIDTH-1:0] issue_rd;
    logic [DATA_WIDTH-1:0] issue_data;
    logic [StW-1:0]        starve_q, starve_d;
    logic                  reg_wr_q;
    logic [ADDR_WIDTH-1:0] rw_q;
    logic [DATA_WIDTH-1:0] bus_w_q;

    reg_writeback_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .push_i        (push),
        .push_entry_i  (push_entry),
        .pop_i         (pop),
        .kill_i        (alu_issue),
        .kill_rd_i     (alu_rd_i),
        .count_o       (count),
        .head_o        (head),
        .entry_valid_o (entry_valid),
        .entry_rd_o    (entry_rd)
    );

    always_comb begin
        head_occ  = (count != '0);
        // Gated on a live head so a head killed while starving does not stall the ALU.
        forced    = (starve_q == StarveMax) && head.valid;
        alu_issue = alu_valid_i && !forced && (alu_rd_i != REG_ZERO);
        // A killed head is discarded even if the ALU holds the write slot.
        pop        = head_occ && (!head.valid || !alu_issue);
        fifo_issue = head.valid && !alu_issue;
        issue      = alu_issue || fifo_issue;
        issue_rd   = alu_issue ? alu_rd_i   : head.rd;
        issue_data = alu_issue ? alu_data_i : head.data;

        mem_ready_o      = (count < CntW'(DEPTH));
        push             = mem_valid_i && mem_ready_o && (mem_rd_i != REG_ZERO);
        push_entry.valid = !(alu_issue && (alu_rd_i == mem_rd_i));
        push_entry.rd    = mem_rd_i;
        push_entry.data  = mem_data_i;

        alu_stall_o = forced && alu_valid_i;
    end

    always_comb begin
        starve_d = starve_q;
        if (pop || !head_occ) begin
            starve_d = '0;
        end else if (head.valid && (starve_q != StarveMax)) begin
            starve_d = starve_q + StW'(1);
        end
    end

    always_comb begin
        pend_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                pend_o[entry_rd[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_wr_q <= 1'b0;
            rw_q     <= '0;
            bus_w_q  <= '0;
            starve_q <= '0;
        end else begin
            reg_wr_q <= issue;
            if (issue) begin
                rw_q    <= issue_rd;
                bus_w_q <= issue_data;
            end
            starve_q <= starve_d;
        end
    end

    assign reg_wr_o     = reg_wr_q;
    assign rw_o         = rw_q;
    assign bus_w_o      = bus_w_q;
    assign fifo_count_o = count;

endmodule
